// File: rtl/dmem_lsu.sv
// dmem_lsu -- load/store initiator between the single-cycle datapath and a
// word-wide data memory.
//
// Accepts RV32I byte/half/word loads and stores, maps byte addresses onto
// memory words, sign/zero-extends load data and performs read-modify-write
// for sb/sh because the memory only writes whole words. Illegal funct3 and
// misaligned requests are answered with resp_err and never touch memory.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_we, req_funct3    1 = store; RV32I load/store funct3
//   req_addr, req_wdata   byte address, store data
//   resp_valid            one-cycle completion pulse
//   resp_rdata, resp_err  extended load data (0 for stores/errors), error flag
//   dmem_wr_en            memory write enable (one cycle per store)
//   dmem_addr             memory address (word index when WORD_ADDR=1)
//   dmem_w_data           memory write data
//   dmem_r_data           memory read data (combinational)
//
// Optional feature (macro LSU_PERF_CNT_EN): adds ld_count / st_count, counting
// successful loads and stores. Without the macro the ports do not exist.

module dmem_lsu #(
  parameter int WORD_ADDR = 1,
  parameter int XLEN      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            dmem_wr_en,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_w_data,
  input  logic [XLEN-1:0] dmem_r_data
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0]     ld_count,
  output logic [31:0]     st_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_WRITE,
    S_RESP
  } state_t;

  state_t      state;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_off;
  logic [15:0] lat_wdata;

  logic            req_legal;
  logic            req_misal;
  logic            req_err;
  logic [XLEN-1:0] req_mem_addr;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic [XLEN-1:0] ld_ext;
  logic [XLEN-1:0] lane_mask;
  logic [XLEN-1:0] lane_data;
  logic [XLEN-1:0] merged;

  // Request decode, evaluated on the live request so the accept edge can
  // branch straight to the right state.
  always_comb begin
    req_legal = 1'b0;
    req_misal = 1'b0;
    if (req_we)
      req_legal = req_funct3 inside {3'b000, 3'b001, 3'b010};
    else
      req_legal = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    case (req_funct3[1:0])
      2'b01:   req_misal = req_addr[0];
      2'b10:   req_misal = (req_addr[1:0] != 2'b00);
      default: req_misal = 1'b0;
    endcase
    req_err = !req_legal || req_misal;
  end

  assign req_mem_addr = (WORD_ADDR != 0) ? {2'b00, req_addr[XLEN-1:2]}
                                         : {req_addr[XLEN-1:2], 2'b00};

  // Load lane selection and extension from the latched request.
  always_comb begin
    case (lat_off)
      2'd0:    rd_byte = dmem_r_data[7:0];
      2'd1:    rd_byte = dmem_r_data[15:8];
      2'd2:    rd_byte = dmem_r_data[23:16];
      default: rd_byte = dmem_r_data[31:24];
    endcase
    rd_half = lat_off[1] ? dmem_r_data[31:16] : dmem_r_data[15:0];
    case (lat_funct3)
      3'b000:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  ld_ext = {24'h0, rd_byte};
      3'b101:  ld_ext = {16'h0, rd_half};
      default: ld_ext = dmem_r_data;
    endcase
  end

  // sb/sh merge: replicate the store data across all lanes, then keep only
  // the addressed lane over the word read back in RMW_RD.
  always_comb begin
    if (lat_funct3[0]) begin
      lane_mask = 32'h0000_FFFF << {lat_off[1], 4'b0000};
      lane_data = {2{lat_wdata}};
    end else begin
      lane_mask = 32'h0000_00FF << {lat_off, 3'b000};
      lane_data = {4{lat_wdata[7:0]}};
    end
    merged = (dmem_r_data & ~lane_mask) | (lane_data & lane_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      lat_funct3  <= 3'b000;
      lat_off     <= 2'b00;
      lat_wdata   <= 16'h0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      dmem_wr_en  <= 1'b0;
      dmem_addr   <= '0;
      dmem_w_data <= '0;
`ifdef LSU_PERF_CNT_EN
      ld_count    <= 32'h0;
      st_count    <= 32'h0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_funct3 <= req_funct3;
            lat_off    <= req_addr[1:0];
            lat_wdata  <= req_wdata[15:0];
            req_ready  <= 1'b0;
            if (req_err) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (!req_we) begin
              state     <= S_LOAD;
              dmem_addr <= req_mem_addr;
            end else if (req_funct3 == 3'b010) begin
              state       <= S_WRITE;
              dmem_addr   <= req_mem_addr;
              dmem_w_data <= req_wdata;
              dmem_wr_en  <= 1'b1;
            end else begin
              state     <= S_RMW_RD;
              dmem_addr <= req_mem_addr;
            end
          end
        end
        S_LOAD: begin
          state      <= S_RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= ld_ext;
`ifdef LSU_PERF_CNT_EN
          ld_count   <= ld_count + 32'd1;
`endif
        end
        S_RMW_RD: begin
          state       <= S_WRITE;
          dmem_w_data <= merged;
          dmem_wr_en  <= 1'b1;
        end
        S_WRITE: begin
          state      <= S_RESP;
          dmem_wr_en <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
`ifdef LSU_PERF_CNT_EN
          st_count   <= st_count + 32'd1;
`endif
        end
        S_RESP: begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
        end
        default: begin
          state      <= S_IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          dmem_wr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        dmem_wr_en;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_w_data;
  logic [31:0] dmem_r_data;
`ifdef LSU_PERF_CNT_EN
  logic [31:0] ld_count;
  logic [31:0] st_count;
`endif

  int checks = 0;
  int failures = 0;

  dmem_lsu dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .dmem_wr_en  (dmem_wr_en),
    .dmem_addr   (dmem_addr),
    .dmem_w_data (dmem_w_data),
    .dmem_r_data (dmem_r_data)
`ifdef LSU_PERF_CNT_EN
    ,
    .ld_count    (ld_count),
    .st_count    (st_count)
`endif
  );

  always #5 clk = ~clk;

  // 16-word memory: combinational read, returns 0 during a write cycle.
  logic [31:0] mem [16];
  always @(posedge clk) if (dmem_wr_en) mem[dmem_addr[3:0]] <= dmem_w_data;
  assign dmem_r_data = dmem_wr_en ? 32'h0 : mem[dmem_addr[3:0]];

  // Reference model state
  logic [31:0] ref_mem [16];
  int          m_ld = 0;
  int          m_st = 0;
  logic        exp_err;
  logic [31:0] exp_rdata;
  int          exp_lat;
  int          exp_nw;
  logic [31:0] exp_wdata;
  logic [31:0] exp_addr;
  logic [31:0] last_rdata;
  logic        last_err;

  // Applies the architectural effect of one request to the model.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    bit legal;
    int size, off, idx;
    logic [31:0] word, v;
    legal = we ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size = 1 << f3[1:0];
    off = int'(addr[1:0]);
    idx = int'((addr >> 2) % 16);
    word = ref_mem[idx];
    exp_err = !legal || ((off % size) != 0);
    exp_addr = addr >> 2;
    exp_nw = 0;
    exp_rdata = 32'h0;
    exp_wdata = 32'h0;
    if (exp_err) begin
      exp_lat = 1;
    end else if (!we) begin
      exp_lat = 2;
      v = word >> (8 * off);
      if (size == 1) begin
        v = v & 32'hFF;
        if (f3 == 3'd0 && v[7]) v = v | 32'hFFFFFF00;
      end else if (size == 2) begin
        v = v & 32'hFFFF;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
      end
      exp_rdata = v;
      m_ld++;
    end else begin
      exp_lat = (size == 4) ? 2 : 3;
      exp_nw = 1;
      v = word;
      for (int b = 0; b < size; b++) v[8*(off+b) +: 8] = wd[8*b +: 8];
      ref_mem[idx] = v;
      exp_wdata = v;
      m_st++;
    end
  endtask

  // Issues one request, follows it to completion and compares against the model.
  // With hold=1, req_valid stays high with junk while busy (must be ignored).
  task automatic do_req(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input bit hold);
    int lat, nw, ready_bad;
    bit got;
    logic [31:0] first_addr, w_addr, w_data, rd;
    logic er;
    model(we, f3, addr, wd);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_before_req: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    if (hold) begin
      req_we = 1'b1; req_funct3 = 3'b010; req_addr = $urandom; req_wdata = $urandom;
    end else begin
      req_valid = 1'b0;
    end
    got = 0; lat = 0; nw = 0; ready_bad = 0;
    first_addr = dmem_addr; w_addr = 0; w_data = 0; rd = 0; er = 0;
    for (int c = 1; c <= 8; c++) begin
      if (req_ready !== 1'b0) ready_bad++;
      if (dmem_wr_en === 1'b1) begin
        nw++; w_addr = dmem_addr; w_data = dmem_w_data;
      end
      if (resp_valid === 1'b1) begin
        got = 1; lat = c; rd = resp_rdata; er = resp_err;
        req_valid = 1'b0;
        break;
      end
      @(posedge clk); #1;
      if (hold) begin
        req_addr = $urandom; req_wdata = $urandom;
      end
    end
    req_valid = 1'b0;
    last_rdata = rd; last_err = er;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s timeout: no resp_valid within 8 cycles", name);
    end
    checks++;
    if (lat != exp_lat) begin
      failures++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    checks++;
    if (rd !== exp_rdata || er !== exp_err) begin
      failures++;
      $display("FAIL %s resp: got rdata=%h err=%b want rdata=%h err=%b", name, rd, er, exp_rdata, exp_err);
    end
    checks++;
    if (nw != exp_nw) begin
      failures++;
      $display("FAIL %s write_count: got %0d want %0d", name, nw, exp_nw);
    end
    if (exp_nw == 1) begin
      checks++;
      if (w_addr !== exp_addr || w_data !== exp_wdata) begin
        failures++;
        $display("FAIL %s write: got addr=%h data=%h want addr=%h data=%h", name, w_addr, w_data, exp_addr, exp_wdata);
      end
    end
    if (!exp_err) begin
      checks++;
      if (first_addr !== exp_addr) begin
        failures++;
        $display("FAIL %s dmem_addr: got %h want %h", name, first_addr, exp_addr);
      end
    end
    checks++;
    if (ready_bad != 0) begin
      failures++;
      $display("FAIL %s ready_busy: got %0d ready cycles want 0", name, ready_bad);
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s after_resp: got valid=%b ready=%b want valid=0 ready=1", name, resp_valid, req_ready);
    end
`ifdef LSU_PERF_CNT_EN
    checks++;
    if (ld_count !== 32'(m_ld) || st_count !== 32'(m_st)) begin
      failures++;
      $display("FAIL %s perf: got ld=%0d st=%0d want ld=%0d st=%0d", name, ld_count, st_count, m_ld, m_st);
    end
`endif
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_ld = 0; m_st = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_resp: got ready=%b valid=%b rdata=%h err=%b want 1 0 0 0", req_ready, resp_valid, resp_rdata, resp_err);
    end
    checks++;
    if (dmem_wr_en !== 1'b0 || dmem_addr !== 32'h0 || dmem_w_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_mem: got wr_en=%b addr=%h w_data=%h want 0 0 0", dmem_wr_en, dmem_addr, dmem_w_data);
    end
`ifdef LSU_PERF_CNT_EN
    checks++;
    if (ld_count !== 32'h0 || st_count !== 32'h0) begin
      failures++;
      $display("FAIL reset_perf: got ld=%0d st=%0d want 0 0", ld_count, st_count);
    end
`endif
  endtask

  task automatic test_init_mem();
    for (int i = 0; i < 16; i++) do_req("init_sw", 1'b1, 3'b010, 32'(i * 4), $urandom, 1'b0);
  endtask

  task automatic test_sw_lw();
    do_req("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
    do_req("lw_10", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    checks++;
    if (last_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL lw_deadbeef: got %h want deadbeef", last_rdata);
    end
  endtask

  task automatic test_sb_rmw();
    do_req("sw_pre", 1'b1, 3'b010, 32'h10, 32'h11223344, 1'b0);
    do_req("sb_11", 1'b1, 3'b000, 32'h11, 32'h000000AA, 1'b0);
    do_req("lw_rmw", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    checks++;
    if (last_rdata !== 32'h1122AA44) begin
      failures++;
      $display("FAIL sb_merge: got %h want 1122aa44", last_rdata);
    end
    do_req("sh_12", 1'b1, 3'b001, 32'h12, 32'hFFFF5566, 1'b0);
    do_req("lw_sh", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    checks++;
    if (last_rdata !== 32'h5566AA44) begin
      failures++;
      $display("FAIL sh_merge: got %h want 5566aa44", last_rdata);
    end
  endtask

  task automatic test_extend();
    logic [31:0] want [4];
    logic [2:0]  f3s  [4];
    logic [31:0] adrs [4];
    want = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF, 32'h00007F01};
    f3s  = '{3'b000, 3'b100, 3'b001, 3'b101};
    adrs = '{32'h12, 32'h12, 32'h12, 32'h10};
    do_req("sw_ext", 1'b1, 3'b010, 32'h10, 32'h80FF7F01, 1'b0);
    for (int i = 0; i < 4; i++) begin
      do_req("ld_ext", 1'b0, f3s[i], adrs[i], 32'h0, 1'b0);
      checks++;
      if (last_rdata !== want[i]) begin
        failures++;
        $display("FAIL extend_%0d: got %h want %h", i, last_rdata, want[i]);
      end
    end
  endtask

  task automatic test_errors();
    do_req("lw_mis", 1'b0, 3'b010, 32'h13, 32'h0, 1'b0);
    do_req("sh_mis", 1'b1, 3'b001, 32'h11, 32'h1234, 1'b0);
    do_req("ld_011", 1'b0, 3'b011, 32'h10, 32'h0, 1'b0);
    do_req("st_100", 1'b1, 3'b100, 32'h10, 32'h5A5A5A5A, 1'b0);
    checks++;
    if (last_err !== 1'b1) begin
      failures++;
      $display("FAIL illegal_store: got err=%b want 1", last_err);
    end
  endtask

  task automatic test_wrap();
    do_req("lw_wrap", 1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 1'b0);
    do_req("sb_wrap", 1'b1, 3'b000, 32'hFFFFFFFF, 32'h000000C3, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_req("b2b_sw", 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 1'b1);
    do_req("b2b_sb", 1'b1, 3'b000, 32'h23, 32'h00000099, 1'b1);
    do_req("b2b_lw", 1'b0, 3'b010, 32'h20, 32'h0, 1'b1);
    do_req("b2b_err", 1'b0, 3'b001, 32'h21, 32'h0, 1'b1);
  endtask

  task automatic test_rst_in_write();
    int seen;
    model(1'b1, 3'b000, 32'h31, 32'h0000007E);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h31; req_wdata = 32'h7E;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (dmem_wr_en !== 1'b1) begin
      failures++;
      $display("FAIL rst_write_setup: got wr_en=%b want 1", dmem_wr_en);
    end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    m_ld = 0; m_st = 0;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || dmem_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL rst_write_idle: got ready=%b valid=%b wr_en=%b want 1 0 0", req_ready, resp_valid, dmem_wr_en);
    end
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL rst_write_noresp: got %0d resp_valid cycles want 0", seen);
    end
    do_req("lw_after_rst", 1'b0, 3'b010, 32'h30, 32'h0, 1'b0);
  endtask

  task automatic test_random();
    logic we;
    logic [2:0] f3;
    logic [31:0] addr;
    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      addr = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
      do_req("rand", we, f3, addr, $urandom, bit'($urandom_range(0, 3) == 0));
    end
  endtask

  task automatic test_perf();
`ifdef LSU_PERF_CNT_EN
    apply_reset();
    do_req("pf_ld1", 1'b0, 3'b010, 32'h00, 32'h0, 1'b0);
    do_req("pf_ld2", 1'b0, 3'b000, 32'h05, 32'h0, 1'b0);
    do_req("pf_ld3", 1'b0, 3'b101, 32'h0A, 32'h0, 1'b0);
    do_req("pf_st1", 1'b1, 3'b010, 32'h08, 32'h1, 1'b0);
    do_req("pf_st2", 1'b1, 3'b001, 32'h0E, 32'h2, 1'b0);
    do_req("pf_mis", 1'b0, 3'b010, 32'h06, 32'h0, 1'b0);
    checks++;
    if (ld_count !== 32'd3 || st_count !== 32'd2) begin
      failures++;
      $display("FAIL perf_counts: got ld=%0d st=%0d want 3 2", ld_count, st_count);
    end
    apply_reset();
    checks++;
    if (ld_count !== 32'd0 || st_count !== 32'd0) begin
      failures++;
      $display("FAIL perf_clear: got ld=%0d st=%0d want 0 0", ld_count, st_count);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
    test_reset();
    test_init_mem();
    test_sw_lw();
    test_sb_rmw();
    test_extend();
    test_errors();
    test_wrap();
    test_back_to_back();
    test_rst_in_write();
    test_random();
    test_perf();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store initiator between the single-cycle datapath and the word-wide data memory.
- Accepts byte/half/word load and store requests (RV32I funct3 encoding).
- Converts byte addresses to word indices, sign/zero-extends load data, and does read-modify-write for sb/sh, since the memory only writes whole words.
- Flags misaligned or illegal requests without touching memory.

Parameters:
- WORD_ADDR, 1, 1: dmem_addr = byte address >> 2 (word index); 0: dmem_addr = byte address with bits [1:0] forced to 0.
- XLEN, 32, data and address width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I load/store funct3
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low byte/half used for sb/sh
- resp_valid  out  1  one-cycle pulse, request complete
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or illegal request; valid with resp_valid
- dmem_wr_en  out  1  memory write enable
- dmem_addr  out  32  memory address
- dmem_w_data  out  32  memory write data
- dmem_r_data  in  32  memory read data; combinational read, returns 0 while dmem_wr_en=1

Behaviour:
- Reset: state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; dmem_wr_en=0; dmem_addr=0; dmem_w_data=0; latched request cleared.
- Accept: on a rising edge where state=IDLE and req_valid=1, latch we/funct3/addr/wdata.
- Decode on accept:
  - Legal loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Legal stores: 000 sb, 001 sh, 010 sw.
  - Any other funct3 is illegal.
  - Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- Transitions:
  - IDLE -> RESP (err=1): illegal or misaligned; no dmem access.
  - IDLE -> LOAD: legal load.
  - IDLE -> WRITE: sw.
  - IDLE -> RMW_RD: sb/sh.
  - LOAD -> RESP: capture dmem_r_data, extend into resp_rdata.
  - RMW_RD -> WRITE: capture dmem_r_data, merge the store byte/half into the lane selected by addr[1:0].
  - WRITE -> RESP.
  - RESP -> IDLE.
- dmem_addr is driven from the latched address in LOAD, RMW_RD and WRITE; it holds its last value otherwise.
- dmem_wr_en=1 only in WRITE, for exactly one cycle per store.
- dmem_wr_en=0 in LOAD and RMW_RD, so reads never see the zeroed write-cycle data.
- Lane select:
  - Byte lane = addr[1:0] (byte k = bits 8k+7:8k).
  - Half lane = addr[1] (bits 15:0 or 31:16).
- Extension: lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
- Latency from the accepting edge to resp_valid high:
  - Error: 1 cycle.
  - Load or sw: 2 cycles.
  - sb/sh: 3 cycles.
- resp_valid is high only in RESP, for exactly 1 cycle. resp_rdata and resp_err are stable while resp_valid=1.
- No back-pressure on responses; the consumer must take resp_valid when it pulses.
- req_ready=0 outside IDLE. req_valid there is ignored and not queued.
- A new request can be accepted in the cycle after RESP.
- rst asserted in any state: next edge forces IDLE with reset values.
  - No resp_valid for the aborted request.
  - If rst is sampled during WRITE, the write still hits memory that edge, because the memory samples wr_en on the same edge.
- Address wrap: no bounds check; addr 0xFFFFFFFC gives word index 0x3FFFFFFF.

Optional Feature:
- Macro: LSU_PERF_CNT_EN.
- Defined: adds outputs ld_count[31:0] and st_count[31:0].
  - Each increments by 1 on entry to RESP with err=0, by request type.
  - Error responses are not counted.
  - Both clear on rst and wrap at 0xFFFFFFFF -> 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- sw addr=0x10 wdata=0xDEADBEEF, then lw addr=0x10 -> one write cycle with dmem_addr=0x4 and w_data=0xDEADBEEF; lw response rdata=0xDEADBEEF err=0, 2 cycles after acceptance.
- Word 0x4 = 0x11223344; sb addr=0x11 wdata=0xAA -> exactly one RMW_RD cycle, then one write of 0x1122AA44; resp_valid 3 cycles after acceptance.
- Word 0x4 = 0x80FF7F01: lb addr=0x12 -> 0xFFFFFFFF; lbu addr=0x12 -> 0x000000FF; lh addr=0x12 -> 0xFFFF80FF; lhu addr=0x10 -> 0x00007F01.
- lw addr=0x13, sh addr=0x11, load funct3=011 -> resp_err=1, rdata=0, dmem_wr_en never 1, resp_valid 1 cycle after acceptance.
- Assert rst while in WRITE during an sb -> IDLE next cycle, no resp_valid; req_ready=1 and a new lw accepted immediately after rst deasserts.
- LSU_PERF_CNT_EN: 3 loads, 2 stores, 1 misaligned load -> ld_count=3, st_count=2; rst -> both 0.
